i2c_reg_sched: RTL and testbench
================================

I2C_REG_SCHED -- requirements
Module: i2c_reg_sched

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, data byte width
- ADDR_W, 4, register index width
- NUM_REGS, 11, number of valid register indices (0..NUM_REGS-1)
- FIFO_DEPTH, 4, I2C write buffer depth (power of two)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic on its rising edge
- rst, in, 1, synchronous reset, active-high
- i2c_valid, in, 1, one-cycle strobe: I2C front end has a decoded write byte
- i2c_addr, in, ADDR_W, register index for i2c_data
- i2c_data, in, DATA_W, write byte
- i2c_ack_ok, out, 1, buffer not full; front end drives ACK only when this is high
- loc_req, in, 1, local requester write request, level, held until granted
- loc_addr, in, ADDR_W, local register index
- loc_data, in, DATA_W, local write byte
- loc_gnt, out, 1, one-cycle pulse: local write accepted
- wr_en, out, 1, register-bank write strobe
- wr_addr, out, ADDR_W, register-bank index
- wr_data, out, DATA_W, register-bank data
- wr_ready, in, 1, bank accepts the write when wr_en && wr_ready
- ovf, out, 1, sticky: an I2C byte arrived while the buffer was full
- busy, out, 1, FSM not in IDLE or FIFO non-empty

Function
REQ-003 An I2C byte with i2c_valid=1 and the FIFO not full SHALL be pushed the same cycle; it is visible to the arbiter on the next cycle.
REQ-004 An I2C byte with i2c_valid=1 and the FIFO full SHALL be dropped, and ovf SHALL be set.
REQ-005 i2c_ack_ok SHALL equal !full, registered from FIFO state.
REQ-006 A simultaneous push and pop on a full FIFO SHALL still drop the incoming byte (full is evaluated before the pop).
REQ-007 FSM states SHALL be IDLE, ISSUE_I2C, ISSUE_LOC.
- IDLE: if requests are pending, go to ISSUE_I2C or ISSUE_LOC per REQ-008.
- ISSUE_x: assert wr_en with the registered address and data; on wr_ready return to IDLE.
REQ-008 Arbitration SHALL be round-robin: when FIFO non-empty and loc_req are both high, grant the source not granted last; after reset, I2C has priority.
REQ-009 In ISSUE_* the outputs wr_en, wr_addr and wr_data SHALL remain stable until wr_ready; there is no timeout.
REQ-010 Entry into ISSUE_I2C SHALL pop the FIFO; entry into ISSUE_LOC SHALL pulse loc_gnt for one cycle and latch loc_addr/loc_data.
REQ-011 A request with addr >= NUM_REGS SHALL be consumed (popped or granted) without asserting wr_en, and the FSM SHALL stay in IDLE.
REQ-012 Minimum latency SHALL be:
- I2C push to wr_en: 2 cycles.
- loc_req to wr_en: 1 cycle.
- Throughput: one write per 2 cycles with wr_ready tied high.
REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra pointer bit to distinguish full from empty.

Reset
REQ-014 While rst=1 at a clock edge, the following SHALL be cleared, taking priority over all inputs:
- state to IDLE
- FIFO pointers (FIFO empty)
- wr_en, loc_gnt, ovf, wr_addr, wr_data to 0
- last-grant register to LOC, so I2C wins first
REQ-015 After reset, i2c_ack_ok SHALL be 1 and busy SHALL be 0.
REQ-016 Reset asserted mid-write SHALL abandon the write; no wr_en is asserted in the cycle after reset.

Configuration
REQ-017 With I2C_SCHED_ERRCNT_EN defined, the block SHALL add an output err_cnt[7:0] counting dropped bytes plus invalid-address requests; it saturates at 255 and is cleared by rst.
REQ-018 Without I2C_SCHED_ERRCNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-019 A shared package i2c_sched_pkg SHALL hold:
- state enum (IDLE, ISSUE_I2C, ISSUE_LOC)
- grant-source enum
- default DATA_W/ADDR_W/NUM_REGS constants
REQ-020 The FIFO SHALL be a sub-module sync_fifo (parameterised width and depth, with push, pop, full, empty); arbitration and the FSM stay in the top.

Verification
REQ-021 The bench SHALL cover the following directed scenarios.
- Single I2C write: addr 3, data 0xA5, wr_ready=1 -> wr_en one cycle, 2 cycles after push, with wr_addr=3, wr_data=0xA5.
- Contention: FIFO holds (1,0x11); loc_req (2,0x22) held; first two grants after reset -> I2C then LOC, then alternating.
- Overflow: 5 pushes in consecutive cycles with wr_ready=0 -> i2c_ack_ok=0 after the 4th push, 5th byte dropped, ovf=1; after wr_ready goes high, exactly 4 writes occur in order.
- Backpressure: wr_ready low for 3 cycles during ISSUE_LOC -> wr_en, wr_addr and wr_data stable for 4 cycles; single write.
- Invalid address: i2c_addr=12 -> no wr_en, FIFO empties; err_cnt increments to 1 when I2C_SCHED_ERRCNT_EN is defined.
- Reset mid-operation: rst during ISSUE_I2C with wr_ready=0 -> next cycle wr_en=0, busy=0, i2c_ack_ok=1, ovf=0.

Source files
------------

// File: rtl/i2c_sched_pkg.sv
// Shared types and default sizing for the I2C/local register-write scheduler.
package i2c_sched_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_NUM_REGS   = 11;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_I2C,
    ISSUE_LOC
  } state_t;

  typedef enum logic {
    SRC_I2C,
    SRC_LOC
  } src_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push while full is ignored even
// if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic             do_push, do_pop, full_d;

  always_comb begin
    do_push     = push && !full;
    do_pop      = pop && !empty;
    wr_ptr_d    = wr_ptr + CNT_W'(do_push);
    rd_ptr_d    = rd_ptr + CNT_W'(do_pop);
    empty_nxt_c = (wr_ptr_d == rd_ptr_d);
    full_d      = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                  (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      full   <= full_d;
      empty  <= empty_nxt_c;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/i2c_reg_sched.sv
// Round-robin scheduler merging buffered I2C writes and a local requester onto
// one register-bank write port. Define I2C_SCHED_ERRCNT_EN to add err_cnt.
module i2c_reg_sched
  import i2c_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_valid,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_data,
  output logic              i2c_ack_ok,
  input  logic              loc_req,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_data,
  output logic              loc_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              ovf,
  output logic              busy
`ifdef I2C_SCHED_ERRCNT_EN
  ,output logic [7:0]       err_cnt
`endif
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] fifo_dout;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full, fifo_empty, fifo_empty_nxt, fifo_pop;

  state_t             state_q, state_d;
  src_t               last_q, last_d;
  logic               wr_en_d, loc_gnt_d, bad_req, drop, i2c_pend, loc_pend;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [DATA_W-1:0]  wr_data_d;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (i2c_valid),
    .din         ({i2c_addr, i2c_data}),
    .pop         (fifo_pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  assign {head_addr, head_data} = fifo_dout;
  assign i2c_ack_ok = ~fifo_full;
  assign drop       = i2c_valid && fifo_full;
  assign i2c_pend   = ~fifo_empty;
  // Mask the request during the grant pulse so a held loc_req is not granted twice.
  assign loc_pend   = loc_req && !loc_gnt;

  // Arbitration and issue control
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wr_en_d   = wr_en;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    loc_gnt_d = 1'b0;
    fifo_pop  = 1'b0;
    bad_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i2c_pend && (!loc_pend || last_q == SRC_LOC)) begin
          fifo_pop = 1'b1;
          last_d   = SRC_I2C;
          if (32'(head_addr) < NUM_REGS) begin
            state_d   = ISSUE_I2C;
            wr_en_d   = 1'b1;
            wr_addr_d = head_addr;
            wr_data_d = head_data;
          end else begin
            bad_req = 1'b1;
          end
        end else if (loc_pend) begin
          loc_gnt_d = 1'b1;
          last_d    = SRC_LOC;
          if (32'(loc_addr) < NUM_REGS) begin
            state_d   = ISSUE_LOC;
            wr_en_d   = 1'b1;
            wr_addr_d = loc_addr;
            wr_data_d = loc_data;
          end else begin
            bad_req = 1'b1;
          end
        end
      end
      ISSUE_I2C, ISSUE_LOC: begin
        if (wr_ready) begin
          state_d = IDLE;
          wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SRC_LOC;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      loc_gnt <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      loc_gnt <= loc_gnt_d;
      ovf     <= ovf | drop;
      busy    <= (state_d != IDLE) || !fifo_empty_nxt;
    end
  end

`ifdef I2C_SCHED_ERRCNT_EN
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  always_comb begin
    err_inc = 2'(bad_req) + 2'(drop);
    err_sum = 9'(err_cnt) + 9'(err_inc);
  end

  // Saturating count of dropped bytes and invalid-address requests
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`else
  logic unused_bad_req;
  assign unused_bad_req = bad_req;
`endif

endmodule

// File: tb/tb_i2c_reg_sched.sv
// Directed self-checking bench for i2c_reg_sched; honours I2C_SCHED_ERRCNT_EN.
module tb_i2c_reg_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i2c_valid = 1'b0;
  logic [3:0] i2c_addr = '0;
  logic [7:0] i2c_data = '0;
  logic       i2c_ack_ok;
  logic       loc_req = 1'b0;
  logic [3:0] loc_addr = '0;
  logic [7:0] loc_data = '0;
  logic       loc_gnt;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready = 1'b0;
  logic       ovf;
  logic       busy;
`ifdef I2C_SCHED_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int gnt_cnt  = 0;
  int en_cnt   = 0;
  logic [11:0] wlog[$];

  always #5 clk = ~clk;

  i2c_reg_sched dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_valid  (i2c_valid),
    .i2c_addr   (i2c_addr),
    .i2c_data   (i2c_data),
    .i2c_ack_ok (i2c_ack_ok),
    .loc_req    (loc_req),
    .loc_addr   (loc_addr),
    .loc_data   (loc_data),
    .loc_gnt    (loc_gnt),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ovf        (ovf),
    .busy       (busy)
`ifdef I2C_SCHED_ERRCNT_EN
    ,.err_cnt   (err_cnt)
`endif
  );

  // Record every accepted bank write plus grant and wr_en activity.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && wr_ready) wlog.push_back({wr_addr, wr_data});
      if (loc_gnt) gnt_cnt++;
      if (wr_en) en_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_i2c(input logic [3:0] a, input logic [7:0] d);
    i2c_valid = 1'b1;
    i2c_addr  = a;
    i2c_data  = d;
    tick();
    i2c_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && wlog.size() < n; i++) tick();
  endtask

  localparam logic [3:0] OV_A [5] = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd4};
  localparam logic [7:0] OV_D [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};

  initial begin
    // Reset state
    tick();
    tick();
    sample();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_loc_gnt", 32'(loc_gnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ack_ok", 32'(i2c_ack_ok), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    tick();
    rst = 1'b0;

    // Single I2C write: wr_en two cycles after the push cycle
    wr_ready  = 1'b1;
    i2c_valid = 1'b1;
    i2c_addr  = 4'd3;
    i2c_data  = 8'hA5;
    tick();
    i2c_valid = 1'b0;
    sample();
    check("single_lat1_wr_en", 32'(wr_en), 32'd0);
    check("single_lat1_busy", 32'(busy), 32'd1);
    tick();
    sample();
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_addr", 32'(wr_addr), 32'd3);
    check("single_wr_data", 32'(wr_data), 32'hA5);
    tick();
    sample();
    check("single_wr_en_drop", 32'(wr_en), 32'd0);
    check("single_count", 32'(wlog.size()), 32'd1);

    // Contention: I2C first after reset, then alternating with a held loc_req
    do_reset();
    wlog.delete();
    gnt_cnt   = 0;
    i2c_valid = 1'b1;
    i2c_addr  = 4'd1;
    i2c_data  = 8'h11;
    tick();
    i2c_addr  = 4'd4;
    i2c_data  = 8'h44;
    loc_req   = 1'b1;
    loc_addr  = 4'd2;
    loc_data  = 8'h22;
    tick();
    i2c_addr  = 4'd5;
    i2c_data  = 8'h55;
    tick();
    i2c_valid = 1'b0;
    wait_log(6, 60);
    loc_req = 1'b0;
    repeat (4) tick();
    check("cont_count", 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6) begin
      check("cont_w0", 32'(wlog[0]), 32'h111);
      check("cont_w1", 32'(wlog[1]), 32'h222);
      check("cont_w2", 32'(wlog[2]), 32'h444);
      check("cont_w3", 32'(wlog[3]), 32'h222);
      check("cont_w4", 32'(wlog[4]), 32'h555);
      check("cont_w5", 32'(wlog[5]), 32'h222);
    end
    check("cont_gnt_pulses", 32'(gnt_cnt), 32'd3);

    // Backpressure in ISSUE_LOC: outputs hold for 4 cycles, one write
    wlog.delete();
    wr_ready = 1'b0;
    loc_req  = 1'b1;
    loc_addr = 4'd7;
    loc_data = 8'h77;
    tick();
    loc_req = 1'b0;
    sample();
    check("bp_loc_gnt", 32'(loc_gnt), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) wr_ready = 1'b1;
      sample();
      check($sformatf("bp_wr_en_c%0d", k), 32'(wr_en), 32'd1);
      check($sformatf("bp_wr_addr_c%0d", k), 32'(wr_addr), 32'd7);
      check($sformatf("bp_wr_data_c%0d", k), 32'(wr_data), 32'h77);
      tick();
    end
    sample();
    check("bp_wr_en_done", 32'(wr_en), 32'd0);
    check("bp_count", 32'(wlog.size()), 32'd1);

    // Invalid addresses: I2C index 12, then local index 11 (== NUM_REGS)
    en_cnt  = 0;
    gnt_cnt = 0;
    push_i2c(4'd12, 8'hEE);
    repeat (4) tick();
    sample();
    check("inv_i2c_no_wr", 32'(en_cnt), 32'd0);
    check("inv_i2c_busy", 32'(busy), 32'd0);
    check("inv_i2c_ack_ok", 32'(i2c_ack_ok), 32'd1);
`ifdef I2C_SCHED_ERRCNT_EN
    check("inv_i2c_err_cnt", 32'(err_cnt), 32'd1);
`endif
    tick();
    loc_req  = 1'b1;
    loc_addr = 4'd11;
    loc_data = 8'hBB;
    tick();
    loc_req = 1'b0;
    sample();
    check("inv_loc_gnt", 32'(loc_gnt), 32'd1);
    repeat (3) tick();
    sample();
    check("inv_loc_no_wr", 32'(en_cnt), 32'd0);
    check("inv_loc_single_gnt", 32'(gnt_cnt), 32'd1);
    check("inv_loc_busy", 32'(busy), 32'd0);
`ifdef I2C_SCHED_ERRCNT_EN
    check("inv_loc_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // Overflow: park the FSM in ISSUE_LOC so the FIFO is not drained
    tick();
    wlog.delete();
    wr_ready = 1'b0;
    loc_req  = 1'b1;
    loc_addr = 4'd9;
    loc_data = 8'h99;
    tick();
    loc_req = 1'b0;
    sample();
    check("ov_park_gnt", 32'(loc_gnt), 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      i2c_valid = 1'b1;
      i2c_addr  = OV_A[k];
      i2c_data  = OV_D[k];
      if (k == 3) begin
        sample();
        check("ov_ack_before_4th", 32'(i2c_ack_ok), 32'd1);
      end
      if (k == 4) begin
        sample();
        check("ov_ack_after_4th", 32'(i2c_ack_ok), 32'd0);
      end
      tick();
    end
    i2c_valid = 1'b0;
    sample();
    check("ov_ovf", 32'(ovf), 32'd1);
    check("ov_ack_full", 32'(i2c_ack_ok), 32'd0);
    tick();
    wr_ready = 1'b1;
    wait_log(5, 40);
    repeat (3) tick();
    check("ov_count", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      check("ov_w_loc", 32'(wlog[0]), 32'h999);
      for (int k = 0; k < 4; k++)
        check($sformatf("ov_w%0d", k), 32'(wlog[k+1]), 32'({OV_A[k], OV_D[k]}));
    end
    sample();
    check("ov_drained_ack", 32'(i2c_ack_ok), 32'd1);
    check("ov_drained_busy", 32'(busy), 32'd0);
`ifdef I2C_SCHED_ERRCNT_EN
    check("ov_err_cnt", 32'(err_cnt), 32'd3);
`endif

    // Reset mid-write: abandoned, state and sticky flags cleared
    tick();
    wlog.delete();
    wr_ready = 1'b0;
    push_i2c(4'd6, 8'h66);
    tick();
    sample();
    check("rmid_wr_en_before", 32'(wr_en), 32'd1);
    check("rmid_ovf_before", 32'(ovf), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("rmid_wr_en", 32'(wr_en), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_ack_ok", 32'(i2c_ack_ok), 32'd1);
    check("rmid_ovf", 32'(ovf), 32'd0);
`ifdef I2C_SCHED_ERRCNT_EN
    check("rmid_err_cnt", 32'(err_cnt), 32'd0);
`endif
    wr_ready = 1'b1;
    repeat (3) tick();
    check("rmid_no_write", 32'(wlog.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
